// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port ids
// and default bus widths.
package ram_arb_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select with a registered "last winner" pointer. In
// round-robin mode a tie goes to the port that did not win last time; in
// fixed mode port 0 always wins a tie. The pointer starts at port 1 so
// port 0 takes the first tie after reset.
module rr_arb2
  import ram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_winner,
  output logic o_any
);

  logic r_last;

  // Pick the winner from the current requests and the last-winner pointer
  always_comb begin
    o_any    = i_req0 | i_req1;
    o_winner = PORT0;
    if (i_req0 && i_req1) begin
      o_winner = (FIXED_PRIO != 0) ? PORT0 : ~r_last;
    end else if (i_req1) begin
      o_winner = PORT1;
    end
  end

  // Remember who won whenever a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT1;
    end else if (i_take) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters. A grant
// pulses in the IDLE cycle whose clock edge latches the request; the RAM is
// then driven for one cycle (write) or two cycles (read, the second one
// holding the address while the RAM output is captured). Completion is
// signalled with a one-cycle wdone/rvalid pulse to the owning port, which
// coincides with IDLE so the next grant can happen in that same cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          wdone0,
  output logic          wdone1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  logic          w_winner;
  logic          w_anyReq;
  logic          w_take;
  logic          r_we;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_wdone0;
  logic          r_wdone1;
  logic          r_rvalid0;
  logic          r_rvalid1;

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_take  (w_take),
    .o_winner(w_winner),
    .o_any   (w_anyReq)
  );

  // Next-state and RAM control; the RAM bus is forced to 0 whenever cen is low
  always_comb begin
    w_nextState = r_state;
    w_take      = 1'b0;
    ram_cen     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    case (r_state)
      IDLE: begin
        if (w_anyReq && !rst) begin
          w_take      = 1'b1;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        ram_cen     = 1'b1;
        ram_wen     = r_we;
        ram_addr    = r_addr;
        ram_din     = r_wdata;
        w_nextState = r_we ? IDLE : RDATA;
      end
      RDATA: begin
        ram_cen     = 1'b1;
        ram_addr    = r_addr;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, request latch, completion pulses and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_owner   <= PORT0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_wdone0  <= 1'b0;
      r_wdone1  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_wdone0  <= 1'b0;
      r_wdone1  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_take) begin
        r_owner <= w_winner;
        r_we    <= (w_winner == PORT1) ? we1 : we0;
        r_addr  <= (w_winner == PORT1) ? addr1 : addr0;
        r_wdata <= (w_winner == PORT1) ? wdata1 : wdata0;
      end
      if (r_state == ACCESS && r_we) begin
        r_wdone0 <= (r_owner == PORT0);
        r_wdone1 <= (r_owner == PORT1);
      end
      if (r_state == RDATA) begin
        r_rdata   <= ram_dout;
        r_rvalid0 <= (r_owner == PORT0);
        r_rvalid1 <= (r_owner == PORT1);
      end
    end
  end

  assign gnt0    = w_take && (w_winner == PORT0);
  assign gnt1    = w_take && (w_winner == PORT1);
  assign wdone0  = r_wdone0;
  assign wdone1  = r_wdone1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority. Each has its own behavioural synchronous RAM. Expected values come
// from a simple model: an array of what each address should hold, the
// "last winner" of each arbiter, and the fixed cycle counts of an access.
module tb_ram_arbiter;

  logic             clk = 1'b0;
  logic [1:0]       rst, req0, req1, we0, we1;
  logic [1:0][31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]       gnt0, gnt1, rvalid0, rvalid1, wdone0, wdone1, busy, ramCen, ramWen;
  logic [1:0][31:0] rdata, ramAddr, ramDin, ramDout;

  logic [31:0] expMem [2][256];
  bit          expLast [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst[0]), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .wdone0(wdone0[0]), .wdone1(wdone1[0]), .rdata(rdata[0]), .busy(busy[0]),
    .ram_cen(ramCen[0]), .ram_wen(ramWen[0]), .ram_addr(ramAddr[0]), .ram_din(ramDin[0]),
    .ram_dout(ramDout[0])
  );

  ram_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .rst(rst[1]), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .wdone0(wdone0[1]), .wdone1(wdone1[1]), .rdata(rdata[1]), .busy(busy[1]),
    .ram_cen(ramCen[1]), .ram_wen(ramWen[1]), .ram_addr(ramAddr[1]), .ram_din(ramDin[1]),
    .ram_dout(ramDout[1])
  );

  // Behavioural single-port RAM per instance: write on cen&wen, registered
  // read on cen&!wen, output forced to 0 while cen is low
  for (genvar g = 0; g < 2; g++) begin : gRam
    logic [31:0] mem [256];
    always @(posedge clk) begin
      if (ramCen[g]) begin
        if (ramWen[g]) mem[ramAddr[g][7:0]] <= ramDin[g];
        else           ramDout[g] <= mem[ramAddr[g][7:0]];
      end else begin
        ramDout[g] <= '0;
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit d, input bit p, input logic req, input logic we,
                               input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      req0[d] = req; we0[d] = we; addr0[d] = a; wdata0[d] = wd;
    end else begin
      req1[d] = req; we1[d] = we; addr1[d] = a; wdata1[d] = wd;
    end
  endtask

  function automatic logic [2:0] pulses(input bit d, input bit p);
    return p ? {gnt1[d], wdone1[d], rvalid1[d]} : {gnt0[d], wdone0[d], rvalid0[d]};
  endfunction

  task automatic checkReset(input bit d, input string tag);
    checkOutput({tag, " ctl"}, 32'({busy[d], ramCen[d], ramWen[d], gnt0[d], gnt1[d],
                                    rvalid0[d], rvalid1[d], wdone0[d], wdone1[d]}), 32'd0);
    checkOutput({tag, " ram_addr"}, ramAddr[d], 32'd0);
    checkOutput({tag, " ram_din"}, ramDin[d], 32'd0);
    checkOutput({tag, " rdata"}, rdata[d], 32'd0);
  endtask

  // Wait (bounded) for any grant and check it went to the expected port
  task automatic waitGnt(input bit d, input bit expPort, input string tag, output int waited);
    waited = 0;
    #1;
    while (gnt0[d] !== 1'b1 && gnt1[d] !== 1'b1 && waited < 12) begin
      tick();
      #1;
      waited++;
    end
    checkOutput({tag, " grant"}, 32'({gnt1[d], gnt0[d]}), expPort ? 32'd2 : 32'd1);
    expLast[d] = expPort;
  endtask

  // From the grant cycle, follow one access to completion and check timing
  task automatic finishAccess(input bit d, input bit p, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input string tag);
    bit          o;
    logic [2:0]  op;
    o = ~p;
    tick();
    applyStimulus(d, p, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    checkOutput({tag, " access ctl"}, 32'({busy[d], ramCen[d], ramWen[d]}), 32'({2'b11, we}));
    checkOutput({tag, " access addr"}, ramAddr[d], a);
    if (we) checkOutput({tag, " access din"}, ramDin[d], wd);
    checkOutput({tag, " access pulses"}, 32'({pulses(d, p), pulses(d, o)}), 32'd0);
    if (we) expMem[d][a[7:0]] = wd;
    tick();
    #1;
    if (we) begin
      checkOutput({tag, " wdone"}, 32'(pulses(d, p)), 32'b010);
    end else begin
      checkOutput({tag, " rdata-phase ctl"}, 32'({busy[d], ramCen[d], ramWen[d]}), 32'b110);
      checkOutput({tag, " rdata-phase pulses"}, 32'({pulses(d, p), pulses(d, o)}), 32'd0);
      tick();
      #1;
      checkOutput({tag, " rvalid"}, 32'(pulses(d, p)), 32'b001);
      checkOutput({tag, " rdata"}, rdata[d], expMem[d][a[7:0]]);
    end
    op = pulses(d, o);
    checkOutput({tag, " other port done"}, 32'(op[1:0]), 32'd0);
    checkOutput({tag, " idle"}, 32'(busy[d]), 32'd0);
  endtask

  // Both ports hold read requests; four grants must follow the priority rule
  task automatic contend(input bit d, input string tag);
    int w;
    int n;
    bit e;
    applyStimulus(d, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    applyStimulus(d, 1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
    for (int k = 0; k < 4; k++) begin
      e = d ? 1'b0 : ~expLast[d];
      waitGnt(d, e, tag, w);
      checkOutput({tag, " grant spacing"}, 32'(w), (k == 0) ? 32'd0 : 32'd2);
      tick();
    end
    applyStimulus(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    n = 0;
    #1;
    while (busy[d] !== 1'b0 && n < 10) begin
      tick();
      #1;
      n++;
    end
    checkOutput({tag, " drain"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin
    int          w;
    bit          p, dual, win;
    logic        opWe [2];
    logic [31:0] opA [2];
    logic [31:0] opD [2];

    rst = 2'b11;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      expMem[0][i] = '0;
      expMem[1][i] = '0;
    end
    expLast[0] = 1'b1;
    expLast[1] = 1'b1;

    tick();
    tick();
    rst = 2'b00;
    #1;
    checkReset(1'b0, "reset rr");
    checkReset(1'b1, "reset fix");

    // Held contention straight after reset: rr alternates from port 0,
    // fixed priority keeps granting port 0
    contend(1'b0, "rr contend");
    contend(1'b1, "fix contend");

    // Port 0 write then read back, port 1 quiet
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    waitGnt(1'b0, 1'b0, "p0 wr", w);
    checkOutput("p0 wr gnt latency", 32'(w), 32'd0);
    checkOutput("p0 wr port1 quiet", 32'(pulses(1'b0, 1'b1)), 32'd0);
    finishAccess(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "p0 wr");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    waitGnt(1'b0, 1'b0, "p0 rd", w);
    checkOutput("p0 rd gnt latency", 32'(w), 32'd0);
    finishAccess(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, "p0 rd");

    // Port 1 write, port 0 reads the same address
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h5, 32'h12345678);
    waitGnt(1'b0, 1'b1, "p1 wr", w);
    finishAccess(1'b0, 1'b1, 1'b1, 32'h5, 32'h12345678, "p1 wr");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'd0);
    waitGnt(1'b0, 1'b0, "p0 rd5", w);
    finishAccess(1'b0, 1'b0, 1'b0, 32'h5, 32'd0, "p0 rd5");

    // Port 1 requests while port 0's read is in its data phase
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    waitGnt(1'b0, 1'b0, "ovl rd", w);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 32'hA5A50001);
    #1;
    checkOutput("ovl held while busy", 32'({gnt1[0], busy[0]}), 32'b01);
    tick();
    waitGnt(1'b0, 1'b1, "ovl p1", w);
    checkOutput("ovl gnt1 with rvalid0", 32'(w), 32'd0);
    checkOutput("ovl rvalid0", 32'(pulses(1'b0, 1'b0)), 32'b001);
    checkOutput("ovl rdata", rdata[0], 32'hDEADBEEF);
    finishAccess(1'b0, 1'b1, 1'b1, 32'h30, 32'hA5A50001, "ovl wr");

    // Reset during the RAM cycle of a read drops it
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'd0);
    waitGnt(1'b0, 1'b0, "rst rd", w);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst[0] = 1'b1;
    #1;
    checkOutput("rst in access", 32'({busy[0], ramCen[0]}), 32'b11);
    tick();
    rst[0] = 1'b0;
    #1;
    checkReset(1'b0, "rst after");
    expLast[0] = 1'b1;
    tick();
    #1;
    checkOutput("rst no rvalid a", 32'({pulses(1'b0, 1'b0), pulses(1'b0, 1'b1)}), 32'd0);
    tick();
    #1;
    checkOutput("rst no rvalid b", 32'({pulses(1'b0, 1'b0), pulses(1'b0, 1'b1)}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h41, 32'hC0FFEE11);
    waitGnt(1'b0, ~expLast[0], "rst first", w);
    finishAccess(1'b0, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, "rst p0");
    waitGnt(1'b0, 1'b1, "rst second", w);
    checkOutput("rst second same cycle", 32'(w), 32'd0);
    finishAccess(1'b0, 1'b1, 1'b1, 32'h41, 32'hC0FFEE11, "rst p1");

    // Preload a small address window, then random traffic against the model
    for (int i = 0; i < 16; i++) begin
      p = (i % 2) != 0;
      opD[0] = $urandom;
      applyStimulus(1'b0, p, 1'b1, 1'b1, 32'(i), opD[0]);
      waitGnt(1'b0, p, "preload", w);
      finishAccess(1'b0, p, 1'b1, 32'(i), opD[0], "preload");
    end
    for (int it = 0; it < 40; it++) begin
      p    = $urandom_range(0, 1) != 0;
      dual = $urandom_range(0, 2) == 0;
      for (int k = 0; k < 2; k++) begin
        opWe[k] = $urandom_range(0, 1) != 0;
        opA[k]  = 32'($urandom_range(0, 15));
        opD[k]  = $urandom;
      end
      if (dual) begin
        applyStimulus(1'b0, 1'b0, 1'b1, opWe[0], opA[0], opD[0]);
        applyStimulus(1'b0, 1'b1, 1'b1, opWe[1], opA[1], opD[1]);
        win = ~expLast[0];
        waitGnt(1'b0, win, "rnd dual", w);
        finishAccess(1'b0, win, opWe[win], opA[win], opD[win], "rnd win");
        waitGnt(1'b0, ~win, "rnd loser", w);
        checkOutput("rnd loser same cycle", 32'(w), 32'd0);
        finishAccess(1'b0, ~win, opWe[~win], opA[~win], opD[~win], "rnd loser");
      end else begin
        applyStimulus(1'b0, p, 1'b1, opWe[p], opA[p], opD[p]);
        waitGnt(1'b0, p, "rnd single", w);
        checkOutput("rnd single latency", 32'(w), 32'd0);
        finishAccess(1'b0, p, opWe[p], opA[p], opD[p], "rnd single");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
